// File: rtl/line_prefetch_buffer_if.sv
// Bus-side read port between the line prefetcher and the Avalon bridge.
// The master issues reads; the slave acknowledges and returns data in the same cycle.
interface line_prefetch_buffer_if #(
  parameter int DW = 128,
  parameter int AW = 26
) ();
  logic [AW-1:0] interface_address;
  logic          interface_read;
  logic [DW-1:0] interface_read_data;
  logic          interface_acknowledge;

  modport master (
    output interface_address,
    output interface_read,
    input  interface_read_data,
    input  interface_acknowledge
  );

  modport slave (
    input  interface_address,
    input  interface_read,
    output interface_read_data,
    output interface_acknowledge
  );
endinterface

// File: rtl/line_prefetch_buffer.sv
// Ping-pong line prefetcher: fills one bank from the bus while the other is displayed.
// Optional LINE_PREFETCH_ERROR_COUNT_EN adds a saturating count of start-during-fetch events.
module line_prefetch_buffer #(
  parameter int INTERFACE_WIDTH_BITS = 128,
  parameter int NUM_BUFFER_ENTRIES   = 64,
  parameter int INTERFACE_ADDR_BITS  = 26,
  localparam int IW = $clog2(NUM_BUFFER_ENTRIES),
  localparam int DW = INTERFACE_WIDTH_BITS,
  localparam int AW = INTERFACE_ADDR_BITS
) (
  input  logic                           interface_clock,
  input  logic                           reset,
  line_prefetch_buffer_if.master         bus,
  input  logic [IW-1:0]                  read_address,
  output logic [DW-1:0]                  read_data,
  input  logic                           start,
  input  logic [AW-1:0]                  base_address,
  input  logic [IW:0]                    line_words,
  output logic                           busy,
  output logic                           fill_done,
  output logic                           display_valid,
  output logic                           timing_error,
  input  logic                           timing_error_reset
`ifdef LINE_PREFETCH_ERROR_COUNT_EN
  ,
  output logic [15:0]                    error_count
`endif
);

  localparam logic [AW-1:0] STRIDE = AW'(DW / 8);
  localparam logic [IW:0]   NMAX   = (IW + 1)'(NUM_BUFFER_ENTRIES);

  typedef enum logic {
    S_IDLE,
    S_FETCH
  } state_e;

  state_e        state_q;
  logic          disp_q;
  logic          ready_q;
  logic          dvalid_q;
  logic          read_q;
  logic          busy_q;
  logic          done_q;
  logic          terr_q;
  logic [AW-1:0] addr_q;
  logic [IW:0]   cnt_q;
  logic [IW:0]   len_q;
  logic [IW:0]   len_d;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] mem_q [2*NUM_BUFFER_ENTRIES];

  logic          ack_w;
  logic          last_w;
  logic          launch_w;
  logic          ready_eff_w;
  logic          err_set_w;
  logic [IW:0]   waddr_w;
  logic [IW:0]   raddr_w;

  always_comb begin
    len_d = line_words;
    if (line_words == '0 || line_words > NMAX) begin
      len_d = NMAX;
    end
  end

  // A final ack retires the fill first, so a coincident start sees it as ready.
  always_comb begin
    ack_w       = (state_q == S_FETCH) && bus.interface_acknowledge;
    last_w      = ack_w && ((cnt_q + 1'b1) == len_q);
    launch_w    = start && ((state_q == S_IDLE) || last_w);
    ready_eff_w = ready_q || last_w;
    err_set_w   = start && (state_q == S_FETCH) && !last_w;
    waddr_w     = {~disp_q, cnt_q[IW-1:0]};
    raddr_w     = {disp_q, read_address};
  end

  always_ff @(posedge interface_clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      disp_q   <= 1'b0;
      ready_q  <= 1'b0;
      dvalid_q <= 1'b0;
      read_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      terr_q   <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
    end else begin
      done_q <= last_w;
      terr_q <= err_set_w | (terr_q & ~timing_error_reset);
      if (ack_w) begin
        cnt_q  <= cnt_q + 1'b1;
        addr_q <= addr_q + STRIDE;
      end
      if (last_w) begin
        state_q <= S_IDLE;
        read_q  <= 1'b0;
        busy_q  <= 1'b0;
        ready_q <= 1'b1;
      end
      if (launch_w) begin
        if (ready_eff_w) begin
          disp_q   <= ~disp_q;
          dvalid_q <= 1'b1;
          ready_q  <= 1'b0;
        end
        state_q <= S_FETCH;
        read_q  <= 1'b1;
        busy_q  <= 1'b1;
        addr_q  <= base_address;
        cnt_q   <= '0;
        len_q   <= len_d;
      end
    end
  end

  always_ff @(posedge interface_clock) begin
    if (ack_w) begin
      mem_q[waddr_w] <= bus.interface_read_data;
    end
  end

  // Reads use the pre-swap display bank; the fill bank is always the other one.
  always_ff @(posedge interface_clock or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_w];
    end
  end

`ifdef LINE_PREFETCH_ERROR_COUNT_EN
  logic [15:0] ecnt_q;

  always_ff @(posedge interface_clock or posedge reset) begin
    if (reset) begin
      ecnt_q <= '0;
    end else if (err_set_w) begin
      if (ecnt_q != 16'hFFFF) begin
        ecnt_q <= ecnt_q + 16'd1;
      end
    end else if (timing_error_reset) begin
      ecnt_q <= '0;
    end
  end

  assign error_count = ecnt_q;
`endif

  assign bus.interface_address = addr_q;
  assign bus.interface_read    = read_q;
  assign read_data             = rdata_q;
  assign busy                  = busy_q;
  assign fill_done             = done_q;
  assign display_valid         = dvalid_q;
  assign timing_error          = terr_q;

endmodule

// File: tb/tb_line_prefetch_buffer.sv
// Randomized bench for line_prefetch_buffer against a line-level reference model.
// Directed test-plan scenarios run first, then a random start/ack/clear mix.
module tb_line_prefetch_buffer;

  localparam int DW = 128;
  localparam int N  = 64;
  localparam int AW = 26;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    read_address;
  logic [DW-1:0] read_data;
  logic          start;
  logic [AW-1:0] base_address;
  logic [6:0]    line_words;
  logic          busy;
  logic          fill_done;
  logic          display_valid;
  logic          timing_error;
  logic          timing_error_reset;
`ifdef LINE_PREFETCH_ERROR_COUNT_EN
  logic [15:0]   error_count;
`endif

  line_prefetch_buffer_if #(.DW(DW), .AW(AW)) bus ();

  line_prefetch_buffer dut (
    .interface_clock    (clk),
    .reset              (reset),
    .bus                (bus),
    .read_address       (read_address),
    .read_data          (read_data),
    .start              (start),
    .base_address       (base_address),
    .line_words         (line_words),
    .busy               (busy),
    .fill_done          (fill_done),
    .display_valid      (display_valid),
    .timing_error       (timing_error),
    .timing_error_reset (timing_error_reset)
`ifdef LINE_PREFETCH_ERROR_COUNT_EN
    ,
    .error_count        (error_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] mdl_mem [2][N];
  bit            mdl_kn  [2][N];
  bit            m_act;
  bit            m_done;
  bit            m_disp;
  bit            m_ready;
  bit            m_dv;
  bit            m_terr;
  int            m_idx;
  int            m_len;
  logic [AW-1:0] m_base;
  logic [DW-1:0] m_rd;
  bit            m_rd_kn;
  int            m_ecnt;

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic check_outs();
    logic [AW-1:0] a;
    chk("read", bus.interface_read, m_act);
    chk("busy", busy, m_act);
    chk("fill_done", fill_done, m_done);
    chk("display_valid", display_valid, m_dv);
    chk("timing_error", timing_error, m_terr);
    if (m_act) begin
      a = m_base + AW'(m_idx * (DW / 8));
      chk("address", bus.interface_address, a);
    end
    if (m_rd_kn) chk("read_data", read_data, m_rd);
`ifdef LINE_PREFETCH_ERROR_COUNT_EN
    chk("error_count", error_count, m_ecnt);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    base_address = '0;
    line_words = '0;
    read_address = '0;
    timing_error_reset = 1'b0;
    bus.interface_acknowledge = 1'b0;
    bus.interface_read_data = '0;
    m_act = 0; m_done = 0; m_disp = 0; m_ready = 0;
    m_dv = 0; m_terr = 0; m_idx = 0; m_len = 0;
    m_base = '0; m_rd = '0; m_rd_kn = 1; m_ecnt = 0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++) mdl_kn[b][i] = 0;
    #1;
    check_outs();
    chk("rst_address", bus.interface_address, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step(input bit st, input logic [AW-1:0] b,
                      input logic [6:0] lw, input bit ack_req,
                      input bit trst, input int ra_sel);
    logic [DW-1:0] d;
    int ra;
    bit ack;
    bit err;
    check_outs();
    d = {$urandom, $urandom, $urandom, $urandom};
    ra = (ra_sel < 0) ? int'($urandom_range(0, N - 1)) : ra_sel;
    ack = ack_req && m_act;
    start = st;
    base_address = b;
    line_words = lw;
    bus.interface_acknowledge = ack;
    bus.interface_read_data = d;
    read_address = ra[5:0];
    timing_error_reset = trst;
    m_rd = mdl_mem[m_disp][ra];
    m_rd_kn = mdl_kn[m_disp][ra];
    m_done = 0;
    if (ack) begin
      mdl_mem[!m_disp][m_idx] = d;
      mdl_kn[!m_disp][m_idx] = 1;
      m_idx++;
      if (m_idx == m_len) begin
        m_act = 0;
        m_ready = 1;
        m_done = 1;
      end
    end
    err = 0;
    if (st) begin
      if (m_act) begin
        err = 1;
      end else begin
        if (m_ready) begin
          m_disp = !m_disp;
          m_dv = 1;
          m_ready = 0;
        end
        m_act = 1;
        m_base = b;
        m_len = (lw == 0 || lw > N) ? N : int'(lw);
        m_idx = 0;
      end
    end
    m_terr = err || (m_terr && !trst);
    if (err) m_ecnt = (m_ecnt == 65535) ? 65535 : m_ecnt + 1;
    else if (trst) m_ecnt = 0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0, -1);
  endtask

  task automatic run_fill(input int dly);
    int c = 0;
    int guard = 0;
    while (m_act && guard < 5000) begin
      guard++;
      step(0, '0, '0, (c == dly), 0, guard % 4);
      c = (c == dly) ? 0 : c + 1;
    end
  endtask

  initial begin
    do_reset();
    idle(2);

    step(1, 26'h100, 7'd4, 0, 0, -1);
    run_fill(0);
    idle(3);

    step(1, 26'h200, 7'd4, 0, 0, -1);
    run_fill(3);
    idle(5);

    step(1, 26'h300, 7'd4, 0, 0, -1);
    step(0, '0, '0, 1, 0, 0);
    step(1, 26'h0999, 7'd9, 0, 0, 1);
    run_fill(1);
    idle(4);
    step(0, '0, '0, 0, 1, 2);
    idle(4);

    step(1, 26'h400, 7'd4, 0, 0, -1);
    while (m_act && m_idx < m_len - 1) step(0, '0, '0, 1, 0, 3);
    step(1, 26'h500, 7'd4, 1, 0, 0);
    run_fill(0);
    idle(3);

    step(1, 26'h3FFFFF0, 7'd0, 0, 0, -1);
    run_fill(0);
    idle(2);
    step(1, 26'h1000, 7'd100, 0, 0, -1);
    run_fill(0);
    idle(70);

    step(1, 26'h2000, 7'd8, 0, 0, -1);
    step(0, '0, '0, 1, 0, -1);
    step(0, '0, '0, 1, 0, -1);
    @(negedge clk);
    do_reset();
    idle(3);

    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 25) == 0,
           AW'($urandom),
           7'($urandom_range(0, 127)),
           ($urandom % 3) == 0,
           ($urandom % 40) == 0,
           -1);
    end
    check_outs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/line_prefetch_buffer.md
# line_prefetch_buffer

Double-buffered line prefetcher between the QSYS/Avalon bridge master port and the pixel pipeline, all in one clock domain. Each `start` does two things. It promotes the most recently completed fill to the display bank. It begins fetching the next line, a run-time number of bus words, into the other bank. It generalises the single-buffer row fetcher with these additions:
- ping-pong banks
- run-time line length
- busy/done status
- completion-aware timing-error detection

## Interface
Parameters:
- `INTERFACE_WIDTH_BITS`, 128: bus word width; must be a multiple of 8.
- `NUM_BUFFER_ENTRIES`, 64: words per bank; must be a power of 2, at least 2.
- `INTERFACE_ADDR_BITS`, 26: byte-address width.

Ports:
- `interface_clock`  in  1  sole clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high.
- `interface_address`  out  INTERFACE_ADDR_BITS  byte address of the current read.
- `interface_read`  out  1  read request.
- `interface_read_data`  in  INTERFACE_WIDTH_BITS  read return data.
- `interface_acknowledge`  in  1  completes the current read; data is valid in the same cycle.
- `read_address`  in  $clog2(NUM_BUFFER_ENTRIES)  display-bank word index.
- `read_data`  out  INTERFACE_WIDTH_BITS  display-bank word.
- `start`  in  1  single-cycle pulse at each line boundary.
- `base_address`  in  INTERFACE_ADDR_BITS  first byte address of the line; sampled with `start`.
- `line_words`  in  $clog2(NUM_BUFFER_ENTRIES)+1  words to fetch; sampled with `start`.
- `busy`  out  1  a fill is in progress.
- `fill_done`  out  1  one-cycle pulse when a fill completes.
- `display_valid`  out  1  the display bank holds a completed line.
- `timing_error`  out  1  sticky error flag.
- `timing_error_reset`  in  1  synchronous clear of `timing_error`.

## Operation
- Bank state: `disp` and `fill` bank indices, with `fill = ~disp`, plus a `ready` flag meaning the fill bank holds a completed, unpromoted line.
- States:
  - IDLE → FETCH on `start`.
  - FETCH → IDLE on the acknowledge of the last word.
- `start` in IDLE:
  - If `ready`: swap `disp`/`fill`, set `display_valid`=1, clear `ready`.
  - If not `ready`: no swap; `display_valid` is unchanged.
  - In both cases, latch `base_address` and the clamped length, zero the word counter, and enter FETCH.
- Length clamp: 0 or any value above `NUM_BUFFER_ENTRIES` fetches `NUM_BUFFER_ENTRIES` words.
- FETCH:
  - Drive `interface_read`=1 and `interface_address` = base + count·(INTERFACE_WIDTH_BITS/8), truncated to INTERFACE_ADDR_BITS (wraps modulo 2^INTERFACE_ADDR_BITS).
  - Hold read and address stable until acknowledge.
  - On acknowledge, write `interface_read_data` to fill-bank entry `count` and increment `count`.
- Last acknowledge: set `ready`, pulse `fill_done`, return to IDLE.
- `start` during FETCH: set `timing_error`. The pulse is otherwise ignored: no swap and no relatch, and the in-progress fill continues to completion.
- Simultaneous `start` and final acknowledge: the fill completes first, then `start` is handled as in IDLE, so the swap promotes the just-finished bank. `timing_error` is not set.
- Simultaneous `timing_error_reset` and a new error: set wins.
- Entries at or beyond the fetched length keep their previous contents.
- The block never issues writes.

## Timing
- Reset values:
  - `interface_read`, `busy`, `fill_done`, `display_valid`, `timing_error`: 0.
  - `interface_address`: 0.
  - `disp`=0, `fill`=1, `ready`=0, state IDLE.
  - `read_data`: 0 in the register; RAM contents undefined.
- `start` at edge t: `interface_read`=1 and `busy`=1 from cycle t+1, with address = base.
- Acknowledge at edge a, not last: the next address is presented at a+1, and `interface_read` stays high with no bubble.
- Last acknowledge at edge a: `interface_read`=0, `busy`=0 and `fill_done`=1 for exactly cycle a+1.
- Best case, a fill of N words completes N+1 cycles after `start`.
- `read_data` is registered with 1-cycle latency. The read at edge t uses `disp` as it was before any swap at edge t.
- `reset` asserted mid-fill: immediate return to reset values. The outstanding bus read is abandoned and the bank contents are undefined.

## Configuration
- `LINE_PREFETCH_ERROR_COUNT_EN`:
  - Defined: adds output `error_count` [15:0]. It increments on each `start` seen in FETCH, saturates at 16'hFFFF, resets to 0 on `reset`, and clears on `timing_error_reset`; increment wins over clear in the same cycle.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, then `start`, base=0x100, `line_words`=4, acknowledge every cycle:
  - addresses 0x100, 0x110, 0x120, 0x130;
  - `fill_done` at cycle 5;
  - `display_valid` stays 0.
- Second `start` with base=0x200 after the first fill: `display_valid`=1, reading entries 0–3 returns the first line's data, and the new fill goes to the other bank.
- Acknowledge delayed 3 cycles per word: `interface_read`/`interface_address` held stable for those cycles; no skipped or duplicated entries.
- `start` during FETCH: `timing_error`=1, the fill still completes with 4 words, and `disp` is unchanged. Then `timing_error_reset` → 0.
- `start` coincident with the final acknowledge: swap occurs, the new fill begins at the next cycle, and `timing_error`=0.
- `line_words`=0: 64 words fetched. Base=0x3FFFFF0: the address wraps to 0x0000000 on word 1.
